multicycle_ctrl: RTL and testbench

//   Multi-cycle main control FSM for the KGP-RISC core. Sequences fetch, decode, execute,

---
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the KGP-RISC core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for each instruction and
// drives the PC/IR/register-file/data-memory enables plus the ALU class code.
// Both memory ports use an ack handshake guarded by a watchdog that halts the
// core with an error code when a memory stops responding.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16  // max wait cycles for an ack; 0 disables the watchdog
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       br_taken,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       halt,
  output logic [1:0] err
);

  // Counter must hold 0..TIMEOUT; keep at least one bit when the watchdog is off.
  localparam int unsigned     CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_LW, C_SW, C_BLTZ, C_BZ, C_BNZ, C_ADDI, C_COMPI, C_JUMP, C_HALT, C_ILLEGAL
  } op_class_e;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMEM    = 2'b10;
  localparam logic [1:0] ERR_DMEM    = 2'b11;

  localparam logic [2:0] ALU_MEM = 3'b001;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            halt_q, halt_d;
  logic [1:0]      err_q, err_d;

  op_class_e       op_class;
  logic [2:0]      dec_alu;
  logic            dec_imm;
  logic            wd_expired;

  // Opcode decode: instruction class, ALU class code and immediate-operand select.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    op_class = C_ILLEGAL;
    dec_alu  = 3'b000;
    dec_imm  = 1'b0;
    unique case (opcode)
      6'b000000: begin op_class = C_R;     dec_alu = 3'b000;                 end
      6'b000001: begin op_class = C_LW;    dec_alu = 3'b001; dec_imm = 1'b1; end
      6'b000010: begin op_class = C_SW;    dec_alu = 3'b001; dec_imm = 1'b1; end
      6'b000011: begin op_class = C_BLTZ;  dec_alu = 3'b010;                 end
      6'b000100: begin op_class = C_BZ;    dec_alu = 3'b011;                 end
      6'b000101: begin op_class = C_BNZ;   dec_alu = 3'b100;                 end
      6'b000110: begin op_class = C_ADDI;  dec_alu = 3'b101; dec_imm = 1'b1; end
      6'b000111: begin op_class = C_COMPI; dec_alu = 3'b110; dec_imm = 1'b1; end
      6'b001000: begin op_class = C_JUMP;  dec_alu = 3'b000;                 end
      6'b111111: begin op_class = C_HALT;                                    end
      default:   begin op_class = C_ILLEGAL;                                 end
    endcase
  end

  // The watchdog fires only when the wait limit is reached; an ack that same cycle still wins.
  assign wd_expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

  // State, watchdog counter and sticky halt/error registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and all control outputs, decoded from state and inputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halt_d   = halt_q;
    err_d    = err_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_PLUS4;
    alu_op   = 3'b000;
    alu_src  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PC_PLUS4;
          state_d = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = ERR_IMEM;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        if (op_class == C_HALT) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = ERR_NONE;
        end else if (op_class == C_ILLEGAL) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = ERR_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_op  = dec_alu;
        alu_src = dec_imm;
        unique case (op_class)
          C_LW, C_SW: state_d = S_MEM;
          C_BLTZ, C_BZ, C_BNZ: begin
            pc_we   = br_taken;
            pc_src  = PC_BRANCH;
            state_d = S_FETCH;
          end
          C_JUMP: begin
            pc_we   = 1'b1;
            pc_src  = PC_JUMP;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;  // R-type, addi, compi
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == C_SW);
        alu_op   = ALU_MEM;
        if (dmem_ack) begin
          state_d = (op_class == C_SW) ? S_FETCH : S_WB;
        end else if (wd_expired) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = ERR_DMEM;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (op_class == C_LW);
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase

    // Every state change starts a fresh wait window for the next FETCH or MEM.
    if (state_d != state_q) cnt_d = '0;

    halt = halt_q;
    err  = err_q;

    // Reset silences every output in the same cycle, aborting any access in flight.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = PC_PLUS4;
      alu_op   = 3'b000;
      alu_src  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      wb_sel   = 1'b0;
      halt     = 1'b0;
      err      = ERR_NONE;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios with literal
// expectations, then randomized stimulus, all compared every cycle against an
// instruction-level reference model (a queue of pending phases per instruction).
module tb_multicycle_ctrl;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       br_taken = 1'b0;
  logic       imem_req, ir_we, pc_we, alu_src, dmem_req, dmem_we, reg_we, wb_sel, halt;
  logic [1:0] pc_src, err;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel), .halt(halt), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] outs();
    return {imem_req, ir_we, pc_we, pc_src, alu_op, alu_src, dmem_req, dmem_we,
            reg_we, wb_sel, halt, err};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       legal;
    bit       is_halt;
    bit [2:0] alu;
    bit       imm;
    bit       ld;
    bit       st;
    bit       br;
    bit       jmp;
  } info_t;

  function automatic info_t classify(input logic [5:0] op);
    info_t i = '0;
    i.legal = 1'b1;
    case (op)
      6'd0:  i.alu = 3'd0;
      6'd1:  begin i.alu = 3'd1; i.imm = 1; i.ld = 1; end
      6'd2:  begin i.alu = 3'd1; i.imm = 1; i.st = 1; end
      6'd3:  begin i.alu = 3'd2; i.br = 1; end
      6'd4:  begin i.alu = 3'd3; i.br = 1; end
      6'd5:  begin i.alu = 3'd4; i.br = 1; end
      6'd6:  begin i.alu = 3'd5; i.imm = 1; end
      6'd7:  begin i.alu = 3'd6; i.imm = 1; end
      6'd8:  i.jmp = 1;
      6'h3F: i.is_halt = 1;
      default: i.legal = 1'b0;
    endcase
    return i;
  endfunction

  localparam byte PH_F = "F";
  localparam byte PH_D = "D";
  localparam byte PH_E = "E";
  localparam byte PH_M = "M";
  localparam byte PH_W = "W";

  byte        phq[$];          // remaining phases of the current instruction; front = now
  bit         m_halted = 1'b0;
  logic [1:0] m_err = 2'b00;
  int         waited = 0;      // cycles spent waiting for the current ack
  bit         m_valid = 1'b0;  // model is meaningful once reset has been seen

  task automatic model_cycle();
    byte   cur;
    info_t inf;
    logic  e_imem_req, e_ir_we, e_pc_we, e_alu_src, e_dmem_req, e_dmem_we;
    logic  e_reg_we, e_wb_sel, e_halt;
    logic [1:0] e_pc_src, e_err;
    logic [2:0] e_alu_op;
    cur = (phq.size() == 0) ? PH_F : phq[0];
    inf = classify(opcode);
    {e_imem_req, e_ir_we, e_pc_we, e_alu_src, e_dmem_req, e_dmem_we, e_reg_we, e_wb_sel, e_halt} = '0;
    e_pc_src = 2'b00; e_err = 2'b00; e_alu_op = 3'b000;

    if (!rst && m_halted) begin
      e_halt = 1'b1;
      e_err  = m_err;
    end else if (!rst) begin
      case (cur)
        PH_F: begin
          e_imem_req = 1'b1;
          if (imem_ack) begin e_ir_we = 1'b1; e_pc_we = 1'b1; end
        end
        PH_E: begin
          e_alu_op  = inf.alu;
          e_alu_src = inf.imm;
          if (inf.br)  begin e_pc_we = br_taken; e_pc_src = 2'b01; end
          if (inf.jmp) begin e_pc_we = 1'b1;     e_pc_src = 2'b10; end
        end
        PH_M: begin
          e_dmem_req = 1'b1;
          e_dmem_we  = inf.st;
          e_alu_op   = 3'b001;
        end
        PH_W: begin
          e_reg_we = 1'b1;
          e_wb_sel = inf.ld;
        end
        default: ;  // DECODE asserts nothing
      endcase
    end

    check("imem_req", imem_req, e_imem_req);
    check("ir_we",    ir_we,    e_ir_we);
    check("pc_we",    pc_we,    e_pc_we);
    check("pc_src",   pc_src,   e_pc_src);
    check("alu_op",   alu_op,   e_alu_op);
    check("alu_src",  alu_src,  e_alu_src);
    check("dmem_req", dmem_req, e_dmem_req);
    check("dmem_we",  dmem_we,  e_dmem_we);
    check("reg_we",   reg_we,   e_reg_we);
    check("wb_sel",   wb_sel,   e_wb_sel);
    check("halt",     halt,     e_halt);
    check("err",      err,      e_err);

    // advance the model to what holds after the coming rising edge
    if (rst) begin
      phq.delete();
      phq.push_back(PH_F);
      m_halted = 1'b0;
      m_err    = 2'b00;
      waited   = 0;
      m_valid  = 1'b1;
    end else if (!m_halted) begin
      case (cur)
        PH_F, PH_M: begin
          if ((cur == PH_F) ? imem_ack : dmem_ack) begin
            void'(phq.pop_front());
            if (cur == PH_F) phq.push_back(PH_D);
            waited = 0;
          end else if (TIMEOUT != 0 && waited == TIMEOUT) begin
            m_halted = 1'b1;
            m_err    = (cur == PH_F) ? 2'b10 : 2'b11;
          end else begin
            waited++;
          end
        end
        PH_D: begin
          void'(phq.pop_front());
          if (!inf.legal) begin
            m_halted = 1'b1; m_err = 2'b01;
          end else if (inf.is_halt) begin
            m_halted = 1'b1; m_err = 2'b00;
          end else begin
            phq.push_back(PH_E);
            if (inf.ld || inf.st) phq.push_back(PH_M);
            if (!inf.st && !inf.br && !inf.jmp) phq.push_back(PH_W);
          end
        end
        default: void'(phq.pop_front());  // EXEC and WB take one cycle
      endcase
      if (phq.size() == 0) phq.push_back(PH_F);
    end
  endtask

  // Compare process: inputs change on the falling edge, outputs are checked 1ns later.
  initial begin
    phq.push_back(PH_F);
    forever begin
      @(negedge clk);
      #1;
      if (rst || m_valid) model_cycle();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input logic [5:0] op, input bit ia, input bit da, input bit bt);
    @(negedge clk);
    rst = r; opcode = op; imem_ack = ia; dmem_ack = da; br_taken = bt;
    #1;
  endtask

  function automatic logic [5:0] pick_op();
    int r = $urandom_range(0, 15);
    if (r == 0) return 6'($urandom);
    if (r == 1) return 6'h3F;
    return 6'($urandom_range(0, 8));
  endfunction

  int cnt;
  bit seen;

  initial begin
    // reset: all outputs low even with acks asserted
    cyc(1, 6'd0, 1, 1, 1);
    check("rst_all_zero", outs(), 16'h0);
    cyc(1, 6'd0, 0, 0, 0);

    // R-type, zero-wait: F D E W then FETCH again
    cyc(0, 6'd0, 1, 0, 0);
    check("r_f_ir_pc", {imem_req, ir_we, pc_we, pc_src}, 5'b11100);
    cyc(0, 6'd0, 0, 0, 0);
    check("r_decode_quiet", outs(), 16'h0);
    cyc(0, 6'd0, 0, 0, 0);
    check("r_exec_alu", {alu_op, alu_src, reg_we}, 5'b00000);
    cyc(0, 6'd0, 0, 0, 0);
    check("r_wb", {reg_we, wb_sel}, 2'b10);
    cyc(0, 6'd0, 0, 0, 0);
    check("r_back_fetch", imem_req, 1'b1);

    // lw with dmem_ack on the 4th MEM cycle (still in FETCH from above)
    cyc(0, 6'd1, 1, 0, 0);
    cyc(0, 6'd1, 0, 0, 0);
    cyc(0, 6'd1, 0, 0, 0);
    check("lw_exec", {alu_op, alu_src}, 4'b0011);
    cnt = 0; seen = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 6'd1, 0, (k == 3), 0);
      cnt += int'(dmem_req);
      seen |= dmem_we;
    end
    check("lw_req_cycles", 16'(cnt), 16'd4);
    check("lw_no_we", 16'(seen), 16'd0);
    cyc(0, 6'd1, 0, 0, 0);
    check("lw_wb", {reg_we, wb_sel}, 2'b11);

    // sw with the same delay: write throughout MEM, then straight to FETCH
    cyc(0, 6'd2, 1, 0, 0);
    cyc(0, 6'd2, 0, 0, 0);
    cyc(0, 6'd2, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 6'd2, 0, (k == 3), 0);
      cnt += int'(dmem_req && dmem_we);
    end
    check("sw_we_cycles", 16'(cnt), 16'd4);
    cyc(0, 6'd2, 0, 0, 0);
    check("sw_no_wb", {imem_req, reg_we}, 2'b10);

    // bz taken then not taken
    for (int t = 1; t >= 0; t--) begin
      cyc(0, 6'd4, 1, 0, 0);
      cyc(0, 6'd4, 0, 0, 0);
      cyc(0, 6'd4, 0, 0, t[0]);
      check("bz_exec", {pc_we, pc_src, alu_op}, {t[0], 2'b01, 3'b011});
      cyc(0, 6'd4, 0, 0, 0);
      check("bz_next_fetch", imem_req, 1'b1);
    end

    // illegal opcode halts with err=01; acks ignored; reset recovers
    cyc(0, 6'b010101, 1, 0, 0);
    cyc(0, 6'b010101, 1, 1, 0);
    check("ill_decode_quiet", outs(), 16'h0);
    for (int k = 0; k < 3; k++) cyc(0, 6'b010101, 1, 1, 1);
    check("ill_halted", outs(), 16'h0005);
    cyc(1, 6'd0, 0, 0, 0);
    check("ill_rst_zero", outs(), 16'h0);
    cyc(0, 6'd0, 0, 0, 0);
    check("ill_after_rst", {imem_req, halt, err}, 4'b1000);

    // imem watchdog: 17 FETCH cycles without ack -> halt, err=10
    cyc(1, 6'd0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 17; k++) begin
      cyc(0, 6'd0, 0, 0, 0);
      cnt += int'(imem_req);
    end
    check("to_fetch_cycles", 16'(cnt), 16'd17);
    cyc(0, 6'd0, 1, 0, 0);
    check("to_halt_err", {halt, err, imem_req, ir_we}, 5'b11000);

    // ack on the 17th FETCH cycle still wins
    cyc(1, 6'd0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 6'd0, 0, 0, 0);
    cyc(0, 6'd0, 1, 0, 0);
    check("late_ack_ir_we", ir_we, 1'b1);
    cyc(0, 6'd0, 0, 0, 0);
    check("late_ack_decode", outs(), 16'h0);
    cyc(0, 6'd0, 0, 0, 0);
    cyc(0, 6'd0, 0, 0, 0);
    check("late_ack_wb", reg_we, 1'b1);

    // reset in the middle of a sw MEM phase with the ack arriving
    cyc(0, 6'd2, 1, 0, 0);
    cyc(0, 6'd2, 0, 0, 0);
    cyc(0, 6'd2, 0, 0, 0);
    cyc(0, 6'd2, 0, 0, 0);
    check("abort_in_mem", {dmem_req, dmem_we}, 2'b11);
    cyc(1, 6'd2, 0, 1, 0);
    check("abort_rst_drop", {dmem_req, dmem_we, reg_we}, 3'b000);
    cyc(0, 6'd2, 0, 0, 0);
    check("abort_fetch", {imem_req, reg_we, halt}, 3'b100);

    // randomized phase, checked entirely by the model
    begin
      int ack_pct = 60;
      for (int c = 0; c < 5000; c++) begin
        if (c % 100 == 0) ack_pct = ($urandom_range(0, 1) != 0) ? 60 : 6;
        @(negedge clk);
        rst = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
        if (m_halted || phq.size() == 0 || phq[0] == PH_F) opcode = pick_op();
        imem_ack = ($urandom_range(0, 99) < ack_pct);
        dmem_ack = ($urandom_range(0, 99) < ack_pct);
        br_taken = 1'($urandom);
      end
    end

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
